// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the 5-stage 16-bit core: controller state
// encoding, the NOP instruction word and the register-index width.
package hazard_stall_ctrl_pkg;

  localparam int REG_W = 3;

  // Instruction word loaded into IF/ID when it is flushed.
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    DRAIN     = 2'd2,
    HALTED    = 2'd3
  } stateT;

endpackage

// File: rtl/hazard_stall_ctrl_hazard_cmp.sv
// Load-use detector: flags an ID-stage read of the register an EX-stage load
// is about to write. Register 0 is a real register, so it is not special-cased.
// Kept standalone so the forwarding unit can reuse the same compare.
module hazard_cmp
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] idRs,
  input  logic             idRsVld,
  input  logic [REG_W-1:0] idRt,
  input  logic             idRtVld,
  input  logic [REG_W-1:0] exRd,
  input  logic             exMemRd,
  output logic             loadUse
);

  // A source matches only when it is actually read by the ID instruction.
  always_comb begin
    loadUse = exMemRd & ((idRsVld & (idRs == exRd)) | (idRtVld & (idRt == exRd)));
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller. Produces PC / IF/ID / ID/EX / EX/MEM
// controls from the hazard inputs and a four-state FSM
// (RUN, DMEM_WAIT, DRAIN, HALTED). Control outputs are combinational from
// state and inputs; halted and stall_cnt are registered. dbg_state exposes
// the FSM state for observation.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_vld,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_vld,
  input  logic             id_halt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_rd,
  input  logic             ex_br_taken,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  stateT          stateQ, stateD;
  logic [DW-1:0]  drainQ;
  logic           drainLoad, drainDec;
  logic           loadUse;
  logic           runRules;

  hazard_cmp uCmp (
    .idRs    (id_rs),
    .idRsVld (id_rs_vld),
    .idRt    (id_rt),
    .idRtVld (id_rt_vld),
    .exRd    (ex_rd),
    .exMemRd (ex_mem_rd),
    .loadUse (loadUse)
  );

  // Leaving DMEM_WAIT is same-cycle: once dmem_stall drops, RUN priority applies.
  assign runRules = (stateQ == RUN) || ((stateQ == DMEM_WAIT) && !dmem_stall);

  // Next state, drain counter controls and the combinational pipeline enables.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_en    = 1'b0;
    stateD      = stateQ;
    drainLoad   = 1'b0;
    drainDec    = 1'b0;
    if (rst) begin
      // Fill the pipe with NOPs while reset is held.
      ifid_en     = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      stateD      = RUN;
    end else if (runRules) begin
      stateD = RUN;
      if (dmem_stall) begin
        stateD = DMEM_WAIT;
      end else if (ex_br_taken) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_en    = 1'b1;
      end else if (loadUse) begin
        idex_bubble = 1'b1;
        exmem_en    = 1'b1;
      end else if (imem_stall) begin
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        exmem_en    = 1'b1;
      end else if (id_halt) begin
        idex_bubble = 1'b1;
        exmem_en    = 1'b1;
        drainLoad   = 1'b1;
        stateD      = DRAIN;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        exmem_en = 1'b1;
      end
    end else begin
      case (stateQ)
        DRAIN: begin
          // Branches are ignored here; only memory back-pressure pauses the drain.
          idex_bubble = 1'b1;
          exmem_en    = ~dmem_stall;
          if (!dmem_stall) begin
            if (drainQ == '0) stateD = HALTED;
            else              drainDec = 1'b1;
          end
        end
        HALTED: begin
          idex_bubble = 1'b1;
        end
        default: begin
          // DMEM_WAIT with dmem_stall still high: everything frozen.
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) stateQ <= RUN;
    else     stateQ <= stateD;
  end

  // Drain counter: counts EX/MEM/WB cycles remaining after HALT decode.
  always_ff @(posedge clk) begin
    if (rst)            drainQ <= '0;
    else if (drainLoad) drainQ <= DW'(DRAIN_CYC - 1);
    else if (drainDec)  drainQ <= drainQ - DW'(1);
  end

  // Halted flag rises on the edge that enters HALTED and holds until reset.
  always_ff @(posedge clk) begin
    if (rst) halted <= 1'b0;
    else     halted <= (stateD == HALTED);
  end

  // Saturating count of non-reset cycles where the PC did not advance.
  always_ff @(posedge clk) begin
    if (rst)                             stall_cnt <= '0;
    else if (!pc_en && stall_cnt != '1)  stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign dbg_state = stateQ;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (DRAIN_CYC=3, CNT_W=4).
// Inputs change 1ns after a rising edge; combinational outputs are sampled
// 1ns later, registered outputs 1ns after the following edge.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       id_rs_vld, id_rt_vld, id_halt, ex_mem_rd, ex_br_taken;
  logic       imem_stall, dmem_stall;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, halted;
  logic [3:0] stall_cnt;
  logic [1:0] dbg_state;
  logic [4:0] ctl;

  int errors = 0;
  int checks = 0;

  hazard_stall_ctrl #(.DRAIN_CYC(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt), .id_rt_vld(id_rt_vld),
    .id_halt(id_halt), .ex_rd(ex_rd), .ex_mem_rd(ex_mem_rd),
    .ex_br_taken(ex_br_taken), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .halted(halted),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en}
  assign ctl = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en};

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    id_rs = 3'd0; id_rs_vld = 1'b0; id_rt = 3'd0; id_rt_vld = 1'b0;
    id_halt = 1'b0; ex_rd = 3'd0; ex_mem_rd = 1'b0; ex_br_taken = 1'b0;
    imem_stall = 1'b0; dmem_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    quiet();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drive_load_use();
    ex_mem_rd = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_vld = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    quiet();
    #1;
    checks++; if (ctl !== 5'b01110) begin errors++; $display("FAIL reset_ctl: got %b exp %b", ctl, 5'b01110); end
    step();
    step();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b exp 0", halted); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", stall_cnt); end
    checks++; if (dbg_state !== RUN) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, RUN); end
    rst = 1'b0;
    #1;
    checks++; if (ctl !== 5'b11001) begin errors++; $display("FAIL post_reset_ctl: got %b exp %b", ctl, 5'b11001); end
    step();
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL post_reset_cnt: got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_load_use();
    #1;
    checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL load_use_ctl: got %b exp %b", ctl, 5'b00011); end
    step();
    quiet();
    #1;
    checks++; if (ctl !== 5'b11001) begin errors++; $display("FAIL load_use_release: got %b exp %b", ctl, 5'b11001); end
    step();
    checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL load_use_cnt: got %0d exp 1", stall_cnt); end
    // rt path on r0: read r0 while a load targets r0 -> hazard
    ex_mem_rd = 1'b1; ex_rd = 3'd0; id_rt = 3'd0; id_rt_vld = 1'b1; id_rs = 3'd5; id_rs_vld = 1'b1;
    #1;
    checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL load_use_r0: got %b exp %b", ctl, 5'b00011); end
    // same registers but not actually read -> no hazard
    id_rt_vld = 1'b0;
    #1;
    checks++; if (ctl !== 5'b11001) begin errors++; $display("FAIL load_use_novld: got %b exp %b", ctl, 5'b11001); end
    // non-load producer -> no hazard
    id_rt_vld = 1'b1; ex_mem_rd = 1'b0;
    #1;
    checks++; if (ctl !== 5'b11001) begin errors++; $display("FAIL load_use_noload: got %b exp %b", ctl, 5'b11001); end
    quiet();
  endtask

  task automatic test_branch_priority();
    do_reset();
    drive_load_use();
    ex_br_taken = 1'b1; imem_stall = 1'b1;
    #1;
    checks++; if (ctl !== 5'b11111) begin errors++; $display("FAIL branch_ctl: got %b exp %b", ctl, 5'b11111); end
    step();
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL branch_cnt: got %0d exp 0", stall_cnt); end
    quiet();
    imem_stall = 1'b1;
    #1;
    checks++; if (ctl !== 5'b01101) begin errors++; $display("FAIL imem_ctl: got %b exp %b", ctl, 5'b01101); end
    step();
    quiet();
  endtask

  task automatic test_dmem_stall();
    do_reset();
    drive_load_use();
    dmem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL dmem_ctl[%0d]: got %b exp %b", i, ctl, 5'b00000); end
      step();
      checks++; if (dbg_state !== DMEM_WAIT) begin errors++; $display("FAIL dmem_state[%0d]: got %0d exp %0d", i, dbg_state, DMEM_WAIT); end
    end
    dmem_stall = 1'b0;
    #1;
    checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL dmem_release_ctl: got %b exp %b", ctl, 5'b00011); end
    step();
    checks++; if (stall_cnt !== 4'd5) begin errors++; $display("FAIL dmem_cnt: got %0d exp 5", stall_cnt); end
    checks++; if (dbg_state !== RUN) begin errors++; $display("FAIL dmem_exit_state: got %0d exp %0d", dbg_state, RUN); end
    quiet();
  endtask

  task automatic test_halt();
    do_reset();
    id_halt = 1'b1;
    #1;
    checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL halt_decode_ctl: got %b exp %b", ctl, 5'b00011); end
    step();                                   // edge 1
    id_halt = 1'b0; dmem_stall = 1'b1;
    #1;
    checks++; if (dbg_state !== DRAIN) begin errors++; $display("FAIL halt_drain_state: got %0d exp %0d", dbg_state, DRAIN); end
    checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL halt_drain_stall_ctl: got %b exp %b", ctl, 5'b00010); end
    step();                                   // edge 2 (counter held)
    dmem_stall = 1'b0; ex_br_taken = 1'b1;
    #1;
    checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL halt_drain_ctl: got %b exp %b", ctl, 5'b00011); end
    step();                                   // edge 3
    step();                                   // edge 4
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b exp 0", halted); end
    step();                                   // edge 5
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_rise: got %b exp 1", halted); end
    checks++; if (dbg_state !== HALTED) begin errors++; $display("FAIL halt_state: got %0d exp %0d", dbg_state, HALTED); end
    id_halt = 1'b1; ex_br_taken = 1'b1;
    #1;
    checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL halted_ctl: got %b exp %b", ctl, 5'b00010); end
    step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_hold: got %b exp 1", halted); end
    checks++; if (stall_cnt !== 4'd6) begin errors++; $display("FAIL halt_cnt: got %0d exp 6", stall_cnt); end
    rst = 1'b1;
    quiet();
    step();
    rst = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || dbg_state !== RUN) begin errors++; $display("FAIL halt_reset_exit: got halted=%b state=%0d exp 0/%0d", halted, dbg_state, RUN); end
    checks++; if (ctl !== 5'b11001) begin errors++; $display("FAIL halt_reset_ctl: got %b exp %b", ctl, 5'b11001); end
  endtask

  task automatic test_saturation();
    do_reset();
    imem_stall = 1'b1;
    repeat (14) step();
    checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_14: got %0d exp 14", stall_cnt); end
    repeat (6) step();
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d exp 15", stall_cnt); end
    quiet();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_priority();
    test_dmem_stall();
    test_halt();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage 16-bit core.
- Drives PC enable, IF/ID enable and flush, ID/EX bubble insertion and EX/MEM freeze.
- Resolves load-use hazards, taken-branch flushes, instruction/data memory stalls and HALT drain.
- Sits beside the IF/ID and ID/EX pipeline registers. Decode and EX supply its hazard inputs; memory stall lines come from the cache/memory wrappers.

Parameters:
- DRAIN_CYC, 3: cycles after HALT is decoded before the halted state is entered (flushes EX, MEM, WB).
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous active-high reset
- id_rs  in  3  ID-stage source register A
- id_rs_vld  in  1  id_rs is actually read
- id_rt  in  3  ID-stage source register B
- id_rt_vld  in  1  id_rt is actually read
- id_halt  in  1  ID holds a HALT instruction
- ex_rd  in  3  EX-stage destination register
- ex_mem_rd  in  1  EX instruction is a load
- ex_br_taken  in  1  EX resolved branch/jump taken
- imem_stall  in  1  instruction memory not ready this cycle
- dmem_stall  in  1  data memory not ready this cycle
- pc_en  out  1  PC register update enable
- ifid_en  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID loads NOP 16'h0800 next edge
- idex_bubble  out  1  ID/EX loads a bubble (all control zero) next edge
- exmem_en  out  1  EX/MEM and MEM/WB enable
- halted  out  1  core halted (registered)
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- States: RUN, DMEM_WAIT, DRAIN, HALTED. Reset → RUN, drain counter 0, stall_cnt 0, halted 0.
- All outputs are combinational from state and inputs except halted and stall_cnt, which are registered.
- While rst=1 the outputs are pc_en=0, ifid_en=1, ifid_flush=1, idex_bubble=1, exmem_en=0, so the pipe fills with NOPs.
- Hazard terms:
  - load_use = ex_mem_rd & ((id_rs_vld & id_rs==ex_rd) | (id_rt_vld & id_rt==ex_rd)).
  - r0 is a real register, so there is no special case for it.
- RUN evaluates conditions in priority order; the first match applies:
  1. dmem_stall: all enables 0, no flush, no bubble. Next state DMEM_WAIT.
  2. ex_br_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1, exmem_en=1. Taken branch overrides a simultaneous load_use or imem_stall.
  3. load_use: pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1. Exactly one bubble per hazard, because the load advances to MEM the next cycle.
  4. imem_stall: pc_en=0, ifid_en=1, ifid_flush=1, exmem_en=1. The fetch bubble is a NOP; downstream keeps flowing.
  5. id_halt: pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1. Drain counter loads DRAIN_CYC-1; next state DRAIN.
  6. Otherwise: pc_en=ifid_en=exmem_en=1, flush=bubble=0.
- DMEM_WAIT:
  - Outputs are frozen exactly as in RUN case 1 while dmem_stall=1.
  - When dmem_stall=0, return to RUN in the same cycle and evaluate RUN rules combinationally. The freeze lasts exactly as many cycles as dmem_stall is high.
- DRAIN:
  - pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=~dmem_stall.
  - The counter decrements only when dmem_stall=0.
  - When the counter is 0 and dmem_stall=0, go to HALTED and set halted=1 at that edge.
  - ex_br_taken is ignored in DRAIN.
- HALTED: all enables 0, bubble=1. Only rst exits this state.
- stall_cnt increments every non-reset cycle with pc_en=0 and saturates at all-ones.
- Reset asserted in any state takes priority over everything and returns to RUN on the next edge.

Decomposition:
- Shared pipeline package holds:
  - state encoding constants (RUN=2'd0, DMEM_WAIT=2'd1, DRAIN=2'd2, HALTED=2'd3);
  - the NOP instruction constant 16'h0800;
  - the register-index width constant 3.
- One natural sub-module, hazard_cmp: purely combinational load_use detector, reused later for a forwarding unit.
- State register, drain counter and stall counter use the existing 16-bit/generic DFF cells with synchronous reset.

Test Plan:
- Reset: hold rst 2 cycles, then release with quiet inputs → ifid_flush=1 and idex_bubble=1 during reset; first cycle after reset pc_en=1, halted=0, stall_cnt=0.
- Load-use: ex_mem_rd=1, ex_rd=3, id_rs=3, id_rs_vld=1 for one cycle → pc_en=0, ifid_en=0, idex_bubble=1 for exactly 1 cycle; stall_cnt=1.
- Branch vs load-use: ex_br_taken=1 together with the same load_use and imem_stall=1 → ifid_flush=1, idex_bubble=1, pc_en=1; stall_cnt unchanged.
- Dmem stall: dmem_stall high 4 cycles with load_use also present → all enables 0 for 4 cycles, state DMEM_WAIT. Cycle 5 applies the load-use bubble. stall_cnt=5.
- Halt with DRAIN_CYC=3: id_halt=1, then dmem_stall=1 for 1 cycle inside DRAIN → halted rises on the 5th edge after id_halt and stays 1. Further ex_br_taken or id_halt have no effect.
- Counter saturation with CNT_W=4: hold imem_stall 20 cycles → stall_cnt reaches 15 and holds at 15.
